// File: rtl/iref_seq_pkg.sv
// Shared definitions for the multi-channel current-reference sequencer:
// register word addresses, sequencer state encoding and STATUS bit layout.
package iref_seq_defs;

  localparam int IREF_SEQ_PD     = 0;
  localparam int IREF_SEQ_LEN    = 1;
  localparam int IREF_SEQ_GAP    = 2;
  localparam int IREF_SEQ_START  = 3;
  localparam int IREF_SEQ_STATUS = 4;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_PEND = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHARGE = 2'd1,
    ST_GAP    = 2'd2
  } seq_state_e;

endpackage

// File: rtl/iref_seq_if.sv
// CPU native valid/ready register bus as seen by the reference sequencer.
interface iref_seq_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) ();
  logic              valid;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic              wstrb;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output valid, address, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iref_seq_prio_enc.sv
// Lowest-set-bit encoder: index of the lowest asserted request and a hit flag.
module iref_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);
  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/iref_seq.sv
// Multi-channel current-reference control with a hardware charge sequencer
// that charges each masked channel in turn, lowest index first.
module iref_seq
  import iref_seq_defs::*;
#(
  parameter int N_CH    = 4,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16,
  parameter int LEN_RST = 16
) (
  input  logic            clk,
  input  logic            rst,
  iref_seq_if.slave       bus,
  output logic [N_CH-1:0] pd,
  output logic [N_CH-1:0] charge,
  output logic            busy
);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  seq_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  gap_q;
  logic [N_CH-1:0]   pending;
  logic              done;

  logic              wr, rd;
  logic              wr_pd, wr_len, wr_gap, wr_start, wr_stat;
  logic [N_CH-1:0]   wmask, pd_nx, eff, pend_left, enc_req, nxt_oh;
  logic [IDX_W-1:0]  enc_idx;
  logic              enc_vld;
  logic              slot_end, abort;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W+7:0] stat_w;
  logic              unused_bits;

  assign busy  = (state != ST_IDLE);
  assign wr    = bus.valid & bus.wstrb;
  assign rd    = bus.valid & ~bus.wstrb;
  assign wmask = bus.wdata[N_CH-1:0];

  assign wr_pd    = wr && (bus.address == ADDR_W'(IREF_SEQ_PD));
  assign wr_len   = wr && (bus.address == ADDR_W'(IREF_SEQ_LEN));
  assign wr_gap   = wr && (bus.address == ADDR_W'(IREF_SEQ_GAP));
  assign wr_start = wr && (bus.address == ADDR_W'(IREF_SEQ_START));
  assign wr_stat  = wr && (bus.address == ADDR_W'(IREF_SEQ_STATUS));

  // pd as it will be after this edge; used to drop channels the same cycle.
  assign pd_nx = wr_pd ? wmask : pd;
  assign eff   = wmask & ~pd;

  // charge holds the one-hot of the active channel while in CHARGE and is
  // zero elsewhere, so masking it out yields the channels still to run.
  assign pend_left = pending & ~charge & ~pd_nx;
  assign enc_req   = (state == ST_IDLE) ? eff : pend_left;
  assign nxt_oh    = N_CH'(1) << enc_idx;

  assign slot_end = (state == ST_CHARGE) &&
                    ((cnt == CNT_W'(1)) || (|(charge & pd_nx)));
  assign abort    = wr_start && busy && (wmask == '0);

  iref_prio_enc #(.N(N_CH), .IDX_W(IDX_W)) u_enc (
    .req (enc_req),
    .idx (enc_idx),
    .vld (enc_vld)
  );

  always_comb begin
    stat_w                      = '0;
    stat_w[STAT_BUSY]           = busy;
    stat_w[STAT_DONE]           = done;
    stat_w[STAT_PEND +: N_CH]   = pending;
    rd_val = '0;
    case (bus.address)
      ADDR_W'(IREF_SEQ_PD):     rd_val = DATA_W'(pd);
      ADDR_W'(IREF_SEQ_LEN):    rd_val = DATA_W'(len_q);
      ADDR_W'(IREF_SEQ_GAP):    rd_val = DATA_W'(gap_q);
      ADDR_W'(IREF_SEQ_STATUS): rd_val = stat_w[DATA_W-1:0];
      default:                  rd_val = '0;
    endcase
  end

  assign unused_bits = &{1'b0, bus.wdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ready <= 1'b0;
      bus.rdata <= '0;
      pd        <= '0;
      charge    <= '0;
      len_q     <= CNT_W'(LEN_RST);
      gap_q     <= '0;
      pending   <= '0;
      done      <= 1'b0;
      cnt       <= '0;
      state     <= ST_IDLE;
    end else begin
      bus.ready <= bus.valid;
      bus.rdata <= rd ? rd_val : '0;

      if (wr_pd)   pd    <= wmask;
      if (wr_len)  len_q <= (bus.wdata[CNT_W-1:0] == '0) ? CNT_W'(1) : bus.wdata[CNT_W-1:0];
      if (wr_gap)  gap_q <= bus.wdata[CNT_W-1:0];
      if (wr_stat) done  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (wr_start && enc_vld) begin
            state   <= ST_CHARGE;
            pending <= eff;
            charge  <= nxt_oh;
            cnt     <= len_q;
            done    <= 1'b0;
          end
        end
        ST_CHARGE: begin
          if (abort) begin
            state   <= ST_IDLE;
            charge  <= '0;
            pending <= '0;
          end else if (slot_end) begin
            pending <= pend_left;
            if (!enc_vld) begin
              state  <= ST_IDLE;
              charge <= '0;
              done   <= 1'b1;
            end else if (gap_q == '0) begin
              charge <= nxt_oh;
              cnt    <= len_q;
            end else begin
              state  <= ST_GAP;
              charge <= '0;
              cnt    <= gap_q;
            end
          end else begin
            pending <= pending & ~pd_nx;
            cnt     <= cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (abort) begin
            state   <= ST_IDLE;
            pending <= '0;
          end else begin
            pending <= pend_left;
            // Every remaining channel powered down during the gap ends the run.
            if (!enc_vld) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else if (cnt == CNT_W'(1)) begin
              state  <= ST_CHARGE;
              charge <= nxt_oh;
              cnt    <= len_q;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          charge <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_iref_seq.sv
// Scoreboard bench for iref_seq: bus reads queue their expected data, a
// monitor pops on ready; charge/busy traces are compared cycle by cycle.
module tb_iref_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pd, charge;
  logic       busy;

  iref_seq_if #(.ADDR_W(3), .DATA_W(32)) bus ();

  iref_seq #(.N_CH(4), .ADDR_W(3), .DATA_W(32), .CNT_W(16), .LEN_RST(16)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .pd     (pd),
    .charge (charge),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct { bit chk; logic [31:0] exp; } sb_t;
  sb_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;
  logic vq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk or posedge rst)
    if (rst) vq <= 1'b0;
    else     vq <= bus.valid;

  // Response monitor: ready must follow each valid by one cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (vq) chk("ready", {31'd0, bus.ready}, 32'd1);
      else if (bus.ready) chk("ready_spur", {31'd0, bus.ready}, 32'd0);
      if (bus.ready) begin
        if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
          sb_t e;
          e = sb.pop_front();
          if (e.chk) chk("rdata", bus.rdata, e.exp);
        end
      end
    end
  end

  task automatic xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                      input bit c, input logic [31:0] e);
    sb_t s;
    s.chk = c; s.exp = e;
    bus.valid = 1'b1; bus.wstrb = w; bus.address = a; bus.wdata = d;
    sb.push_back(s);
    @(posedge clk); #1;
    bus.valid = 1'b0; bus.wstrb = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    xfer(1'b1, a, d, 1'b0, 32'd0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e);
    xfer(1'b0, a, 32'd0, 1'b1, e);
  endtask

  // Sample n cycles; chp holds one expected charge nibble per cycle, bp one busy bit.
  task automatic trace(input string tag, input int n, input logic [63:0] chp, input logic [15:0] bp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_chg"}, {28'd0, charge}, {28'd0, chp[4*i +: 4]});
      chk({tag, "_busy"}, {31'd0, busy}, {31'd0, bp[i]});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.valid = 1'b0; bus.wstrb = 1'b0; bus.address = '0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pd", {28'd0, pd}, 32'd0);
    chk("rst_charge", {28'd0, charge}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset values and readback
    rd(3'd1, 32'd16);
    rd(3'd4, 32'd0);
    rd(3'd2, 32'd0);
    wr(3'd0, 32'hA);
    rd(3'd0, 32'hA);
    rd(3'd3, 32'd0);
    rd(3'd7, 32'd0);
    chk("pd_out", {28'd0, pd}, 32'hA);
    wr(3'd0, 32'h0);

    // Basic sequence: 3-cycle slots, 2-cycle gap, channels 0 and 2
    wr(3'd1, 32'd3);
    wr(3'd2, 32'd2);
    wr(3'd3, 32'b0101);
    trace("basic", 10, 64'h0044400111, 16'h00FF);
    rd(3'd4, 32'h2);

    // Zero length stored as 1, no gap, back-to-back channels
    wr(3'd1, 32'd0);
    rd(3'd1, 32'd1);
    wr(3'd2, 32'd0);
    wr(3'd3, 32'b0011);
    trace("b2b", 4, 64'h0021, 16'h0003);
    rd(3'd4, 32'h2);
    wr(3'd4, 32'd0);
    rd(3'd4, 32'h0);

    // Powered-down channel masked out of the start mask
    wr(3'd1, 32'd2);
    wr(3'd2, 32'd1);
    wr(3'd0, 32'b0010);
    wr(3'd3, 32'b0011);
    trace("pdmask", 4, 64'h0011, 16'h0003);
    wr(3'd3, 32'b0010);
    @(negedge clk);
    chk("pdmask_nostart", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rd(3'd4, 32'h2);

    // Abort and ignore
    wr(3'd0, 32'h0);
    wr(3'd1, 32'd100);
    wr(3'd3, 32'hF);
    rd(3'd4, 32'h0F01);
    idle(7);
    wr(3'd3, 32'b0100);
    @(negedge clk);
    chk("ignore_chg", {28'd0, charge}, 32'h1);
    @(posedge clk); #1;
    idle(8);
    wr(3'd3, 32'd0);
    @(negedge clk);
    chk("abort_chg", {28'd0, charge}, 32'h0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rd(3'd4, 32'h0);

    // Powering down the active channel ends its slot immediately
    wr(3'd1, 32'd10);
    wr(3'd2, 32'd0);
    wr(3'd3, 32'b0011);
    wr(3'd0, 32'b0001);
    @(negedge clk);
    chk("pdslot_chg", {28'd0, charge}, 32'h2);
    @(posedge clk); #1;
    rd(3'd4, 32'h0201);
    wr(3'd3, 32'd0);
    wr(3'd0, 32'h0);

    // Async reset mid-charge
    wr(3'd1, 32'd50);
    wr(3'd0, 32'b0001);
    wr(3'd3, 32'b0010);
    @(negedge clk);
    chk("pre_rst_chg", {28'd0, charge}, 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("arst_chg", {28'd0, charge}, 32'h0);
    chk("arst_pd", {28'd0, pd}, 32'h0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    rd(3'd1, 32'd16);
    rd(3'd2, 32'd0);
    rd(3'd0, 32'd0);
    rd(3'd4, 32'd0);

    idle(3);
    chk("sb_drain", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/iref_seq.md
Name: iref_seq

Overview:
- Multi-channel successor to the single-channel current-reference control block. Drives per-channel power-down and charge lines for N_CH reference cells.
- Adds a hardware charge sequencer: the CPU writes a channel mask and the block charges each selected channel in turn, lowest index first.
- Each charge lasts a programmable number of cycles, with a programmable gap between channels.
- Sits on the CPU native valid/ready bus beside the other analog-control peripherals.

Parameters:
N_CH, 4, number of reference channels (1..DATA_W)
ADDR_W, 3, word-address width of register map
DATA_W, 32, CPU data width
CNT_W, 16, width of charge-length and gap-length counters
LEN_RST, 16, reset value of CHARGE_LEN

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
valid  in  1  CPU request strobe
address  in  ADDR_W  register word address
wdata  in  DATA_W  write data
wstrb  in  1  1=write, 0=read
rdata  out  DATA_W  read data, valid with ready
ready  out  1  one-cycle acknowledge
pd  out  N_CH  per-channel power-down
charge  out  N_CH  per-channel charge enable (at most one bit high)
busy  out  1  sequencer active

Behaviour:
- Reset (async, rst=1): pd=0, charge=0, busy=0, ready=0, rdata=0, CHARGE_LEN=LEN_RST, GAP_LEN=0, pending=0, done=0, FSM=IDLE.
- Bus: valid at cycle T -> ready=1 at T+1 for exactly one cycle; rdata registered at the same edge. Back-to-back valid is accepted every cycle.
- Register map (word address):
  - 0 PD: rw, bits[N_CH-1:0].
  - 1 CHARGE_LEN: rw, [CNT_W-1:0]; a write of 0 is stored as 1.
  - 2 GAP_LEN: rw, [CNT_W-1:0].
  - 3 START: wo, channel mask; reads return 0.
  - 4 STATUS: ro. bit0=busy, bit1=done (sticky), bits[N_CH+7:8]=pending. Any write to STATUS clears done.
  - Unmapped addresses: reads return 0, writes are ignored.
- START write in IDLE, with eff = wdata[N_CH-1:0] & ~pd:
  - eff≠0: pending=eff, FSM -> CHARGE at T+1, done cleared.
  - eff=0: no action; done unchanged.
- START write while busy:
  - mask=0 aborts: charge=0, pending=0, FSM -> IDLE at T+1, done not set.
  - nonzero mask is ignored.
- FSM IDLE: charge=0, busy=0.
- FSM CHARGE:
  - ch = lowest set bit of pending; charge[ch]=1; counter loads CHARGE_LEN; stays in state for exactly CHARGE_LEN cycles.
  - On exit, clear pending[ch].
  - If pending is then nonzero: go to GAP, or straight to CHARGE on the next channel if GAP_LEN=0 (back-to-back, no idle cycle).
  - If pending is then zero: go to IDLE and set done.
- FSM GAP: charge=0, busy=1 for GAP_LEN cycles, then CHARGE.
- Channel powered down mid-sequence:
  - Writing pd[i]=1 while charge[i]=1 drops charge[i] the next cycle and ends that channel's slot immediately, as on a normal slot exit.
  - A pending channel whose pd goes high is dropped from pending.
- CHARGE_LEN/GAP_LEN writes during a sequence take effect at the next counter load.
- Counters are CNT_W unsigned; no wrap, because each load is at least 1.
- busy=1 whenever FSM≠IDLE; busy is combinational from the state register.
- All outputs are registered, except busy.

Decomposition:
- Shared package/header iref_seq_defs: register addresses (IREF_SEQ_PD, _LEN, _GAP, _START, _STATUS), FSM state encodings, STATUS bit positions.
- One sub-module: iref_prio_enc, a parametrised N_CH lowest-set-bit encoder producing index and valid. The rest stays flat.

Test Plan:
- Reset/readback: release rst, read addr 1 -> 16, addr 4 -> 0. Write PD=0xA, read back -> 0xA, pd=4'b1010. Ready is high exactly one cycle after each valid.
- Basic sequence: LEN=3, GAP=2, START=0b0101 -> charge[0] high 3 cycles, 2 idle cycles, charge[2] high 3 cycles. done=1, busy=0 at end; total busy = 8 cycles.
- GAP=0 and LEN write of 0: LEN stored as 1, START=0b0011 -> charge[0] for 1 cycle, then charge[1] for 1 cycle with no gap; STATUS reads 0x2.
- PD masking: PD=0b0010, START=0b0011 -> only channel 0 charges. Then START=0b0010 -> no action, busy stays 0, done unchanged.
- Abort and ignore: LEN=100, START=0b1111; at cycle 10 write START=0b0100 -> ignored. At cycle 20 write START=0 -> charge=0 and busy=0 next cycle, done=0.
- Async reset mid-charge: assert rst while charge[1]=1 -> charge, pd and busy go to 0 without a clock edge; registers return to reset values.
